// File: rtl/mole_pkg.sv
// Shared constants, state types and hole-draw helpers for the mole spawner.
package mole_pkg;

    localparam logic [3:0] POS_NONE  = 4'd0;
    localparam logic [3:0] POS_MIN   = 4'd1;
    localparam logic [3:0] POS_MAX   = 4'd9;
    localparam logic [3:0] POS_CLEAR = 4'd11;

    // Fibonacci taps 8,6,5,4 -> bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [1:0] {LnIdle, LnShow, LnClear, LnGap} lane_state_e;
    typedef enum logic [1:0] {RndIdle, RndRun, RndEnd, RndDone} round_state_e;

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], ^(l & LFSR_TAPS)};
    endfunction

    // Map an LFSR value to a hole, bumping past the previous hole so none repeats.
    function automatic logic [3:0] pick_hole(input logic [7:0] l, input logic [3:0] prev);
        logic [3:0] c;
        c = 4'(l % 8'd9) + 4'd1;
        if (c == prev) c = (c == POS_MAX) ? POS_MIN : c + 4'd1;
        return c;
    endfunction

endpackage

// File: rtl/mole_lane.sv
// One player's spawn FSM: hole draw, hit edge detect, hold/gap timing and score/miss counters.
module mole_lane
    import mole_pkg::*;
#(
    parameter logic [7:0]  SEED       = 8'hA5,
    parameter int unsigned HOLD_TICKS = 8,
    parameter int unsigned GAP_TICKS  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_i,
    input  logic       start_i,
    input  logic       stop_i,
    input  logic       run_i,
    input  logic       hit_i,
    output logic [3:0] pos_o,
    output logic [7:0] score_o,
    output logic [7:0] miss_o
);

    lane_state_e state_q;
    logic [7:0]  lfsr_q;
    logic [3:0]  prev_q;
    logic [3:0]  pos_q;
    logic [7:0]  score_q;
    logic [7:0]  miss_q;
    logic [15:0] hold_q;
    logic [15:0] gap_q;
    logic        hit_q;

    logic [7:0] lfsr_nxt;
    logic [3:0] hole_nxt;
    logic       hit_edge;

    always_comb begin
        lfsr_nxt = lfsr_step(lfsr_q);
        hole_nxt = pick_hole(lfsr_nxt, prev_q);
        hit_edge = hit_i & ~hit_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LnIdle;
            lfsr_q  <= SEED;
            prev_q  <= POS_NONE;
            pos_q   <= POS_NONE;
            score_q <= '0;
            miss_q  <= '0;
            hold_q  <= '0;
            gap_q   <= '0;
            hit_q   <= 1'b0;
        end else begin
            // Edge register samples in every state so a held hit never re-scores.
            hit_q <= hit_i;
            if (start_i) begin
                score_q <= '0;
                miss_q  <= '0;
                hold_q  <= '0;
                lfsr_q  <= lfsr_nxt;
                prev_q  <= hole_nxt;
                pos_q   <= hole_nxt;
                state_q <= LnShow;
            end else if (stop_i) begin
                pos_q   <= POS_CLEAR;
                state_q <= LnClear;
            end else begin
                unique case (state_q)
                    LnIdle: ;
                    LnShow: begin
                        if (hit_edge) begin
                            if (score_q != 8'hFF) score_q <= score_q + 8'd1;
                            pos_q   <= POS_CLEAR;
                            state_q <= LnClear;
                        end else if (tick_i) begin
                            if (hold_q == 16'(HOLD_TICKS - 1)) begin
                                if (miss_q != 8'hFF) miss_q <= miss_q + 8'd1;
                                pos_q   <= POS_CLEAR;
                                state_q <= LnClear;
                            end else begin
                                hold_q <= hold_q + 16'd1;
                            end
                        end
                    end
                    LnClear: begin
                        if (!run_i) begin
                            pos_q   <= POS_NONE;
                            state_q <= LnIdle;
                        end else if (GAP_TICKS == 0) begin
                            hold_q  <= '0;
                            lfsr_q  <= lfsr_nxt;
                            prev_q  <= hole_nxt;
                            pos_q   <= hole_nxt;
                            state_q <= LnShow;
                        end else begin
                            gap_q   <= '0;
                            pos_q   <= POS_NONE;
                            state_q <= LnGap;
                        end
                    end
                    LnGap: begin
                        if (tick_i) begin
                            if (gap_q == 16'(GAP_TICKS - 1)) begin
                                hold_q  <= '0;
                                lfsr_q  <= lfsr_nxt;
                                prev_q  <= hole_nxt;
                                pos_q   <= hole_nxt;
                                state_q <= LnShow;
                            end else begin
                                gap_q <= gap_q + 16'd1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign pos_o   = pos_q;
    assign score_o = score_q;
    assign miss_o  = miss_q;

endmodule

// File: rtl/mole_spawner.sv
// Round FSM and timer driving two independent mole lanes.
module mole_spawner
    import mole_pkg::*;
#(
    parameter int unsigned HOLD_TICKS  = 8,
    parameter int unsigned GAP_TICKS   = 3,
    parameter int unsigned ROUND_TICKS = 600,
    parameter logic [7:0]  SEED_0      = 8'hA5,
    parameter logic [7:0]  SEED_1      = 8'h3C
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       hit_0,
    input  logic       hit_1,
    output logic [3:0] pos_0,
    output logic [3:0] pos_1,
    output logic       active,
    output logic       round_done,
    output logic [7:0] score_0,
    output logic [7:0] score_1,
    output logic [7:0] miss_0,
    output logic [7:0] miss_1
);

    localparam int unsigned RW = $clog2(ROUND_TICKS + 1);

    round_state_e  state_q;
    logic [RW-1:0] cnt_q;
    logic          active_q;
    logic          done_q;

    logic lane_start;
    logic lane_stop;
    logic lane_run;

    always_comb begin
        lane_start = start & ((state_q == RndIdle) | (state_q == RndDone));
        lane_stop  = (state_q == RndRun) & tick & (cnt_q == RW'(ROUND_TICKS - 1));
        lane_run   = (state_q == RndRun);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RndIdle;
            cnt_q    <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            unique case (state_q)
                RndIdle, RndDone: begin
                    if (start) begin
                        cnt_q    <= '0;
                        active_q <= 1'b1;
                        done_q   <= 1'b0;
                        state_q  <= RndRun;
                    end
                end
                RndRun: begin
                    if (tick) begin
                        if (cnt_q == RW'(ROUND_TICKS - 1)) state_q <= RndEnd;
                        else cnt_q <= cnt_q + 1'b1;
                    end
                end
                // One clk while the lanes show CLEAR before going quiet.
                RndEnd: begin
                    active_q <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= RndDone;
                end
            endcase
        end
    end

    assign active     = active_q;
    assign round_done = done_q;

    mole_lane #(
        .SEED      (SEED_0),
        .HOLD_TICKS(HOLD_TICKS),
        .GAP_TICKS (GAP_TICKS)
    ) u_lane_0 (
        .clk    (clk),
        .rst    (rst),
        .tick_i (tick),
        .start_i(lane_start),
        .stop_i (lane_stop),
        .run_i  (lane_run),
        .hit_i  (hit_0),
        .pos_o  (pos_0),
        .score_o(score_0),
        .miss_o (miss_0)
    );

    mole_lane #(
        .SEED      (SEED_1),
        .HOLD_TICKS(HOLD_TICKS),
        .GAP_TICKS (GAP_TICKS)
    ) u_lane_1 (
        .clk    (clk),
        .rst    (rst),
        .tick_i (tick),
        .start_i(lane_start),
        .stop_i (lane_stop),
        .run_i  (lane_run),
        .hit_i  (hit_1),
        .pos_o  (pos_1),
        .score_o(score_1),
        .miss_o (miss_1)
    );

endmodule

// File: tb/tb_mole_spawner.sv
// Directed bench for mole_spawner with a countdown-based reference model checked every cycle.
module tb_mole_spawner;

    localparam int HOLD  = 8;
    localparam int GAP   = 3;
    localparam int ROUND = 20;

    logic       clk = 1'b0;
    logic       rst, tick, start, hit_0, hit_1;
    logic [3:0] pos_0, pos_1;
    logic       active, round_done;
    logic [7:0] score_0, score_1, miss_0, miss_1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mole_spawner #(
        .HOLD_TICKS (HOLD),
        .GAP_TICKS  (GAP),
        .ROUND_TICKS(ROUND)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .start     (start),
        .hit_0     (hit_0),
        .hit_1     (hit_1),
        .pos_0     (pos_0),
        .pos_1     (pos_1),
        .active    (active),
        .round_done(round_done),
        .score_0   (score_0),
        .score_1   (score_1),
        .miss_0    (miss_0),
        .miss_1    (miss_1)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model. Lane phase: 0 none, 1 mole up, 2 clear marker, 3 gap.
    // Round phase: 0 idle, 1 running, 2 ending (clear clk), 3 done.
    int m_phase[2], m_left[2], m_gleft[2], m_hole[2], m_lfsr[2];
    int m_score[2], m_miss[2], m_hitp[2];
    int m_rphase, m_rt;

    function automatic int next_lfsr(input int l);
        int fb;
        fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
        return ((l << 1) | fb) & 255;
    endfunction

    task automatic draw(input int i);
        int c;
        m_lfsr[i] = next_lfsr(m_lfsr[i]);
        c = m_lfsr[i] % 9 + 1;
        if (c == m_hole[i]) c = (c == 9) ? 1 : c + 1;
        m_hole[i] = c;
    endtask

    function automatic int m_pos(input int i);
        if (m_phase[i] == 1) return m_hole[i];
        if (m_phase[i] == 2) return 11;
        return 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        int  h[2];
        bit  begin_r, end_r, rise;
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_phase[i] = 0; m_left[i] = 0; m_gleft[i] = 0; m_hole[i] = 0;
                m_score[i] = 0; m_miss[i] = 0; m_hitp[i] = 0;
            end
            m_lfsr[0] = 'hA5;
            m_lfsr[1] = 'h3C;
            m_rphase  = 0;
            m_rt      = 0;
        end else begin
            h[0]    = int'(hit_0);
            h[1]    = int'(hit_1);
            begin_r = start && (m_rphase == 0 || m_rphase == 3);
            end_r   = (m_rphase == 1) && tick && (m_rt == ROUND - 1);
            for (int i = 0; i < 2; i++) begin
                rise = (h[i] != 0) && (m_hitp[i] == 0);
                if (begin_r) begin
                    m_score[i] = 0; m_miss[i] = 0;
                    draw(i); m_phase[i] = 1; m_left[i] = HOLD;
                end else if (end_r) begin
                    m_phase[i] = 2;
                end else if (m_phase[i] == 1) begin
                    if (rise) begin
                        m_score[i] = (m_score[i] < 255) ? m_score[i] + 1 : 255;
                        m_phase[i] = 2;
                    end else if (tick) begin
                        m_left[i]--;
                        if (m_left[i] == 0) begin
                            m_miss[i]  = (m_miss[i] < 255) ? m_miss[i] + 1 : 255;
                            m_phase[i] = 2;
                        end
                    end
                end else if (m_phase[i] == 2) begin
                    if (m_rphase == 2) m_phase[i] = 0;
                    else begin m_phase[i] = 3; m_gleft[i] = GAP; end
                end else if (m_phase[i] == 3 && tick) begin
                    m_gleft[i]--;
                    if (m_gleft[i] == 0) begin draw(i); m_phase[i] = 1; m_left[i] = HOLD; end
                end
                m_hitp[i] = h[i];
            end
            if (begin_r) begin
                m_rphase = 1; m_rt = 0;
            end else if (m_rphase == 1 && tick) begin
                if (m_rt == ROUND - 1) m_rphase = 2;
                else m_rt++;
            end else if (m_rphase == 2) begin
                m_rphase = 3;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("pos_0", int'(pos_0), m_pos(0));
            chk("pos_1", int'(pos_1), m_pos(1));
            chk("active", int'(active), int'(m_rphase == 1 || m_rphase == 2));
            chk("round_done", int'(round_done), int'(m_rphase == 3));
            chk("score_0", int'(score_0), m_score[0]);
            chk("score_1", int'(score_1), m_score[1]);
            chk("miss_0", int'(miss_0), m_miss[0]);
            chk("miss_1", int'(miss_1), m_miss[1]);
        end
    end

    // Entered at a negedge; drives the next posedge and returns at the following negedge.
    task automatic cyc(input logic t);
        tick = t;
        @(negedge clk);
    endtask

    task automatic do_tick();
        cyc(1'b0);
        cyc(1'b0);
        cyc(1'b1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1'b0);
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; start = 1'b0; hit_0 = 1'b0; hit_1 = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst pos_0", int'(pos_0), 0);
        chk("rst active", int'(active), 0);
        chk("rst round_done", int'(round_done), 0);
        chk("rst score_0", int'(score_0), 0);
        rst = 1'b0;
        repeat (2) do_tick();
        chk("idle pos_0", int'(pos_0), 0);
        chk("idle active", int'(active), 0);

        // Round 1: first holes follow from the seeds (A5 -> 4A -> hole 3, 3C -> 79 -> hole 5).
        pulse_start();
        chk("start pos_0", int'(pos_0), 3);
        chk("start pos_1", int'(pos_1), 5);
        chk("start active", int'(active), 1);

        repeat (2) do_tick();
        hit_0 = 1'b1;
        cyc(1'b0);
        chk("hit pos_0", int'(pos_0), 11);
        chk("hit score_0", int'(score_0), 1);
        chk("hit miss_0", int'(miss_0), 0);
        chk("hit pos_1", int'(pos_1), 5);
        cyc(1'b0);
        chk("gap pos_0", int'(pos_0), 0);

        // Hit stays high through the gap: next mole (4A -> 95 -> hole 6) must not score.
        repeat (3) do_tick();
        chk("reshow pos_0", int'(pos_0), 6);
        repeat (2) do_tick();
        chk("held hit score_0", int'(score_0), 1);
        hit_0 = 1'b0;
        cyc(1'b0);
        hit_0 = 1'b1;
        cyc(1'b0);
        chk("rehit score_0", int'(score_0), 2);
        hit_0 = 1'b0;

        do_tick();
        chk("timeout pos_1", int'(pos_1), 11);
        chk("timeout miss_1", int'(miss_1), 1);
        repeat (3) do_tick();
        chk("second hole pos_1", int'(pos_1), 1);

        // Hit rising on the timeout tick: hit wins.
        repeat (6) do_tick();
        cyc(1'b0);
        cyc(1'b0);
        hit_0 = 1'b1;
        cyc(1'b1);
        chk("race score_0", int'(score_0), 3);
        chk("race miss_0", int'(miss_0), 0);
        chk("race pos_0", int'(pos_0), 11);
        hit_0 = 1'b0;

        do_tick();
        chk("late miss_1", int'(miss_1), 2);
        do_tick();
        chk("end pos_0", int'(pos_0), 11);
        chk("end pos_1", int'(pos_1), 11);
        chk("end active", int'(active), 1);
        cyc(1'b0);
        chk("done pos_0", int'(pos_0), 0);
        chk("done active", int'(active), 0);
        chk("done round_done", int'(round_done), 1);
        repeat (2) do_tick();
        chk("done hold", int'(round_done), 1);

        // Round 2, with a start pulse mid-round that must be ignored.
        pulse_start();
        chk("restart score_0", int'(score_0), 0);
        chk("restart round_done", int'(round_done), 0);
        chk("restart active", int'(active), 1);
        do_tick();
        hit_1 = 1'b1;
        cyc(1'b0);
        hit_1 = 1'b0;
        chk("r2 score_1", int'(score_1), 1);
        do_tick();
        pulse_start();
        do_tick();

        // Asynchronous reset mid-round.
        #2 rst = 1'b1;
        #1;
        chk("arst pos_0", int'(pos_0), 0);
        chk("arst pos_1", int'(pos_1), 0);
        chk("arst active", int'(active), 0);
        chk("arst score_1", int'(score_1), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) do_tick();
        chk("post rst pos_0", int'(pos_0), 0);
        chk("post rst active", int'(active), 0);
        pulse_start();
        chk("reseed pos_0", int'(pos_0), 3);
        chk("reseed pos_1", int'(pos_1), 5);
        repeat (4) do_tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mole_spawner.md
Name: mole_spawner

Overview:
- Generates the per-player mole positions `pos_0` / `pos_1` that the hit judge consumes.
- Consumes the judge's `hit_0` / `hit_1`, keeps hit/miss scores and runs the round timer.
- Each player has its own spawn FSM, driven by a slow `tick` enable from the game clock divider.
- Position code, per player: 0 = no mole; 1..9 = hole (keypad Q W E / A S D / Z X C); 11 = CLEAR marker, which re-arms the judge.

Parameters:
- HOLD_TICKS, 8: ticks a mole stays visible before it counts as a miss.
- GAP_TICKS, 3: ticks with no mole between CLEAR and the next spawn.
- ROUND_TICKS, 600: ticks per round.
- SEED_0, 8'hA5: LFSR seed for player 0; must be non-zero.
- SEED_1, 8'h3C: LFSR seed for player 1; must be non-zero.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- tick  in  1  one-clk enable pulse from divider
- start  in  1  one-clk pulse; begins a round
- hit_0  in  1  judge result, player 0; level, held until CLEAR
- hit_1  in  1  judge result, player 1
- pos_0  out  4  player 0 mole position code
- pos_1  out  4  player 1 mole position code
- active  out  1  round running; drives the judge's ready input
- round_done  out  1  high after round end, until next start
- score_0  out  8  player 0 hits, saturating
- score_1  out  8  player 1 hits, saturating
- miss_0  out  8  player 0 timeouts, saturating
- miss_1  out  8  player 1 timeouts, saturating

Behaviour:
- Reset (async): all outputs 0; FSMs in IDLE; LFSRs loaded with SEED_0 / SEED_1; all counters 0.
- Top level: IDLE --start--> RUN. `active` = 1 in RUN. Scores and misses clear to 0 on start. The round counter counts ticks in RUN. When it reaches ROUND_TICKS-1 and a tick arrives:
  - both players are forced to CLEAR;
  - next clk: DONE, with `active` = 0, `pos` = 0, `round_done` = 1.
  - DONE --start--> RUN, which clears `round_done` the same edge.
- start in RUN is ignored.
- Per-player FSM: IDLE, SHOW, CLEAR, GAP.
  - Entry to RUN → SHOW with a freshly drawn hole.
  - SHOW: `pos` = hole. The hold counter increments on tick.
    - Rising edge of hit (registered previous value) → score +1, then CLEAR.
    - Otherwise, hold counter = HOLD_TICKS-1 with tick → miss +1, then CLEAR.
    - Hit edge and timeout in the same clk → hit wins (score only).
  - CLEAR: `pos` = 11 for exactly one clk, independent of tick; then GAP.
  - GAP: `pos` = 0 for GAP_TICKS ticks, then SHOW with a new hole. GAP_TICKS = 0 → straight to SHOW on the next clk.
  - hit is ignored outside SHOW. A hit still high on entry to SHOW is not an edge: the edge register keeps sampling in every state.
- Hole draw: 8-bit Fibonacci LFSR, taps 8,6,5,4, advanced once per draw.
  - Candidate = (lfsr mod 9) + 1.
  - If candidate equals the previous hole, use candidate+1, wrapping 9→1. No hole repeats back-to-back.
  - The draw registers on the clk that enters SHOW; `pos` is valid that same edge.
- Players are fully independent; simultaneous events on both players are handled in parallel.
- Counters are 8-bit and saturate at 255. The round counter is wide enough for ROUND_TICKS.
- `pos` values 10, 12-15 are never driven.

Decomposition:
- Package `mole_pkg`:
  - position constants POS_NONE = 0, POS_CLEAR = 11, POS_MIN = 1, POS_MAX = 9;
  - per-player state enum;
  - LFSR tap constant.
- Sub-module `mole_lane`: one per player. Holds the FSM, LFSR, edge detect and the score and miss counters. Parameterised by seed, HOLD_TICKS and GAP_TICKS.
- `mole_spawner` holds the round FSM and timer and instantiates two lanes.

Test Plan:
- Reset, then start, no hits, HOLD_TICKS = 8 → each lane shows a hole in 1..9 for 8 ticks, then `pos` = 11 for 1 clk, then `pos` = 0 for 3 ticks, then a new hole that differs from the previous one; `miss_0` = `miss_1` = 1.
- Assert `hit_0` 2 ticks into SHOW and hold it high until CLEAR → `score_0` = 1, `miss_0` = 0; `pos_0` = 11 on the next clk; `hit_1` stays idle, so lane 1 is unaffected.
- `hit_0` rises on the same clk as the timeout tick → `score_0` +1, `miss_0` unchanged.
- Hold `hit_0` high through GAP into the next SHOW → no score increment until hit falls and rises again.
- ROUND_TICKS = 20: run the round to its end → both `pos` = 11 for one clk, then 0; `active` = 0, `round_done` = 1. A second start → scores = 0, `round_done` = 0, `active` = 1.
- Assert rst mid-SHOW → all outputs 0 immediately and asynchronously; after release, no activity until start.
